// File: rtl/mux_nx1_scanner.sv
// mux_nx1_scanner: registered N:1 channel mux with manual select or auto-scan.
// Define MUX_CH_MASK_EN to add a ch_mask input that excludes channels from selection.
module mux_nx1_scanner #(
  parameter int unsigned NUM_CH = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned SEL_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH*DATA_W-1:0] din,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     mode,
  input  logic                     en,
`ifdef MUX_CH_MASK_EN
  input  logic [NUM_CH-1:0]        ch_mask,
`endif
  output logic [DATA_W-1:0]        dout,
  output logic                     dout_valid,
  output logic [SEL_W-1:0]         ch_idx,
  output logic                     scan_wrap,
  output logic                     sel_err
);

  typedef enum logic {ST_MANUAL = 1'b0, ST_SCAN = 1'b1} state_e;

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  state_e            state_q;
  logic [SEL_W-1:0]  cnt_q;
  logic [SEL_W-1:0]  ch_idx_q;
  logic [DATA_W-1:0] dout_q;
  logic              dout_valid_q;
  logic              scan_wrap_q;
  logic              sel_err_q;

  logic [NUM_CH-1:0] mask_c;
  logic              any_c;
  logic              ge_hit_c;
  logic              sel_masked_c;
  logic              man_ok_c;
  logic [SEL_W-1:0]  first_any_c;
  logic [SEL_W-1:0]  first_ge_c;
  logic [SEL_W-1:0]  last_c;
  logic [SEL_W-1:0]  scan_ptr_c;
  logic [SEL_W-1:0]  ptr_c;
  logic [SEL_W-1:0]  cnt_nxt_c;
  logic [DATA_W-1:0] data_c;

`ifdef MUX_CH_MASK_EN
  assign mask_c = ch_mask;
`else
  assign mask_c = '0;
`endif

  // Scan target: first unmasked channel at/after cnt, else wrap to lowest unmasked
  always_comb begin
    any_c        = 1'b0;
    ge_hit_c     = 1'b0;
    sel_masked_c = 1'b0;
    first_any_c  = '0;
    first_ge_c   = '0;
    last_c       = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (!mask_c[i]) begin
        if (!any_c) first_any_c = SEL_W'(i);
        if (!ge_hit_c && (SEL_W'(i) >= cnt_q)) begin
          first_ge_c = SEL_W'(i);
          ge_hit_c   = 1'b1;
        end
        any_c  = 1'b1;
        last_c = SEL_W'(i);
      end else if (SEL_W'(i) == sel) begin
        sel_masked_c = 1'b1;
      end
    end
    scan_ptr_c = ge_hit_c ? first_ge_c : first_any_c;
  end

  assign man_ok_c  = (32'(sel) < NUM_CH) && !sel_masked_c;
  assign ptr_c     = (state_q == ST_SCAN) ? scan_ptr_c : sel;
  assign cnt_nxt_c = (scan_ptr_c == LAST_CH) ? '0 : scan_ptr_c + SEL_W'(1);

  always_comb begin
    data_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (SEL_W'(i) == ptr_c) data_c = din[i*DATA_W +: DATA_W];
    end
  end

  // Mode FSM and registered outputs; pointer always uses the pre-edge state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_MANUAL;
      cnt_q        <= '0;
      ch_idx_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      scan_wrap_q  <= 1'b0;
      sel_err_q    <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      scan_wrap_q  <= 1'b0;
      sel_err_q    <= 1'b0;
      case (state_q)
        ST_MANUAL: begin
          cnt_q <= '0;
          if (en) begin
            if (man_ok_c) begin
              dout_q       <= data_c;
              ch_idx_q     <= ptr_c;
              dout_valid_q <= 1'b1;
            end else begin
              dout_q    <= '0;
              sel_err_q <= 1'b1;
            end
          end
          if (mode) state_q <= ST_SCAN;
        end
        ST_SCAN: begin
          if (en && any_c) begin
            dout_q       <= data_c;
            ch_idx_q     <= ptr_c;
            dout_valid_q <= 1'b1;
            scan_wrap_q  <= (scan_ptr_c == last_c);
            cnt_q        <= cnt_nxt_c;
          end
          if (!mode) begin
            state_q <= ST_MANUAL;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign ch_idx     = ch_idx_q;
  assign scan_wrap  = scan_wrap_q;
  assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_mux_nx1_scanner.sv
// Directed bench for mux_nx1_scanner: an 8-channel and a 6-channel instance, din channel k = 0x10+k.
// Channel-mask vectors run only when MUX_CH_MASK_EN is defined.
module tb_mux_nx1_scanner;

  logic        clk;
  logic        rst_n;
  logic        mode;
  logic        en;
  logic [2:0]  sel8;
  logic [2:0]  sel6;
  logic [63:0] din8;
  logic [47:0] din6;
`ifdef MUX_CH_MASK_EN
  logic [7:0]  ch_mask8;
`endif

  logic [7:0] dout8, dout6;
  logic [2:0] ch_idx8, ch_idx6;
  logic       valid8, valid6, wrap8, wrap6, err8, err6;

  int n_tests = 0;
  int n_fail  = 0;

  mux_nx1_scanner #(.NUM_CH(8), .DATA_W(8), .SEL_W(3)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .din(din8), .sel(sel8), .mode(mode), .en(en),
`ifdef MUX_CH_MASK_EN
    .ch_mask(ch_mask8),
`endif
    .dout(dout8), .dout_valid(valid8), .ch_idx(ch_idx8), .scan_wrap(wrap8), .sel_err(err8)
  );

  mux_nx1_scanner #(.NUM_CH(6), .DATA_W(8), .SEL_W(3)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .din(din6), .sel(sel6), .mode(mode), .en(en),
`ifdef MUX_CH_MASK_EN
    .ch_mask(6'h00),
`endif
    .dout(dout6), .dout_valid(valid6), .ch_idx(ch_idx6), .scan_wrap(wrap6), .sel_err(err6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    mode  = 1'b0;
    en    = 1'b0;
    sel8  = 3'd0;
    sel6  = 3'd0;
    din8  = 64'h1716_1514_1312_1110;
    din6  = 48'h1514_1312_1110;
`ifdef MUX_CH_MASK_EN
    ch_mask8 = 8'h00;
`endif
    repeat (2) tick();
    check("rst_dout",  64'(dout8),  64'h0);
    check("rst_valid", 64'(valid8), 64'h0);
    check("rst_chidx", 64'(ch_idx8), 64'h0);
    check("rst_err",   64'(err8),   64'h0);
    rst_n = 1'b1;

    // Manual select of channel 5
    sel8 = 3'd5; en = 1'b1;
    tick();
    check("man_dout",  64'(dout8),   64'h15);
    check("man_chidx", 64'(ch_idx8), 64'd5);
    check("man_valid", 64'(valid8),  64'h1);
    check("man_err",   64'(err8),    64'h0);
    en = 1'b0;
    tick();
    check("man_hold_dout",  64'(dout8),  64'h15);
    check("man_hold_valid", 64'(valid8), 64'h0);

    // Auto-scan for 10 samples
    mode = 1'b1;
    tick();
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("scan_dout%0d", i),  64'(dout8),  64'(8'h10 + 8'(i % 8)));
      check($sformatf("scan_valid%0d", i), 64'(valid8), 64'h1);
      check($sformatf("scan_wrap%0d", i),  64'(wrap8),  64'((i % 8) == 7));
    end
    mode = 1'b0; en = 1'b0;
    tick();

    // Scan with en toggling 1,0,1
    mode = 1'b1;
    tick();
    en = 1'b1;
    tick();
    check("tog_dout0",  64'(dout8),  64'h10);
    check("tog_valid0", 64'(valid8), 64'h1);
    en = 1'b0;
    tick();
    check("tog_hold_dout",  64'(dout8),  64'h10);
    check("tog_hold_valid", 64'(valid8), 64'h0);
    en = 1'b1;
    tick();
    check("tog_dout1",  64'(dout8),   64'h11);
    check("tog_chidx1", 64'(ch_idx8), 64'd1);

    // Mode change with en on the same edge still scans; manual applies next edge
    mode = 1'b0; sel8 = 3'd5;
    tick();
    check("mchg_old_state", 64'(dout8), 64'h12);
    tick();
    check("mchg_new_state", 64'(dout8), 64'h15);

    // Out-of-range select on the 6-channel instance
    sel6 = 3'd2;
    tick();
    check("r6_ok_dout", 64'(dout6), 64'h12);
    sel6 = 3'd7;
    tick();
    check("r6_bad_dout",  64'(dout6),   64'h0);
    check("r6_bad_valid", 64'(valid6),  64'h0);
    check("r6_bad_err",   64'(err6),    64'h1);
    check("r6_bad_chidx", 64'(ch_idx6), 64'd2);
    en = 1'b0;
    tick();
    check("r6_err_pulse", 64'(err6), 64'h0);

    // 6-channel scan wraps after channel 5
    mode = 1'b1;
    tick();
    en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("s6_dout%0d", i), 64'(dout6), 64'(8'h10 + 8'(i % 6)));
      check($sformatf("s6_wrap%0d", i), 64'(wrap6), 64'((i % 6) == 5));
    end
    mode = 1'b0; en = 1'b0;
    tick();

    // Reset mid-scan after channel 3
    mode = 1'b1;
    tick();
    en = 1'b1;
    repeat (4) tick();
    check("mid_dout3", 64'(dout8), 64'h13);
    rst_n = 1'b0;
    #1;
    check("mid_rst_dout",  64'(dout8),   64'h0);
    check("mid_rst_chidx", 64'(ch_idx8), 64'h0);
    check("mid_rst_valid", 64'(valid8),  64'h0);
    check("mid_rst_wrap",  64'(wrap8),   64'h0);
    en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    tick();
    check("restart_dout",  64'(dout8),  64'h10);
    check("restart_valid", 64'(valid8), 64'h1);
    mode = 1'b0; en = 1'b0;
    tick();

`ifdef MUX_CH_MASK_EN
    // Masked scan: channels 1,3,4,6 excluded
    ch_mask8 = 8'h5A;
    mode = 1'b1;
    tick();
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_d;
      case (i % 4)
        0: exp_d = 8'h10;
        1: exp_d = 8'h12;
        2: exp_d = 8'h15;
        default: exp_d = 8'h17;
      endcase
      tick();
      check($sformatf("mask_dout%0d", i), 64'(dout8), 64'(exp_d));
      check($sformatf("mask_wrap%0d", i), 64'(wrap8), 64'((i % 4) == 3));
    end
    ch_mask8 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("allmask_valid%0d", i), 64'(valid8), 64'h0);
    end
    ch_mask8 = 8'h5A; mode = 1'b0; en = 1'b0;
    tick();
    sel8 = 3'd1; en = 1'b1;
    tick();
    check("mask_man_err",   64'(err8),   64'h1);
    check("mask_man_valid", 64'(valid8), 64'h0);
    en = 1'b0;
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
